usb_stream_pkt_ctrl: RTL and testbench
======================================

Name: usb_stream_pkt_ctrl

Overview:
- Write sequencer for the FX2 slave-FIFO stream endpoint.
- Pops 16-bit words from the stream-side FWFT FIFO (stream_fifo output) and drives SLWR_N/DATA toward the FX2.
- Counts words per USB packet; commits short packets with a PKTEND pulse after a configurable idle timeout, so low-rate trigger data reaches the host without waiting for a full packet.
- Replaces the constant PKTEND_N/FIFOADDR tie-offs at the top level; runs entirely in the USB stream clock domain.

Parameters:
- PKT_WORDS, 256, words per full USB packet (512 bytes); the FX2 auto-commits at this boundary.
- TIMEOUT_WIDTH, 16, width of the idle-timeout counter and TIMEOUT input.
- EP_ADDR, 2'b10, constant value driven on FIFOADDR (EP6).

Ports:
- STREAM_CLK  in  1  stream clock (FX2 IFCLK).
- STREAM_RST_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  quasi-static enable; 0 = stop popping and writing.
- TIMEOUT  in  TIMEOUT_WIDTH  idle cycles before a partial packet is committed; 0 = never commit on timeout.
- FIFO_EMPTY  in  1  source FIFO empty.
- FIFO_DATA  in  16  FWFT head word, valid while FIFO_EMPTY=0.
- FIFO_READ  out  1  pop strobe (combinational).
- FULL_N  in  1  FX2 endpoint-full flag, active low (FLAGS_N[1]).
- FX2RDY  in  1  FX2 ready.
- SLWR_N  out  1  registered write strobe, active low.
- DATA  out  16  registered write data.
- PKTEND_N  out  1  registered packet-end strobe, active low.
- FIFOADDR  out  2  constant EP_ADDR.
- WORD_CNT  out  log2(PKT_WORDS)  words in the current uncommitted packet.

Behaviour:
- Reset values: SLWR_N=1, PKTEND_N=1, DATA=0, FIFO_READ=0, WORD_CNT=0, state=IDLE, idle counter=0.
- rdy = FULL_N & FX2RDY, registered once (rdy_q); all decisions use rdy_q.
- FSM states: IDLE, WRITE, COMMIT, GAP.
- IDLE: go to WRITE when ENABLE=1.
- WRITE, write decision: a cycle writes when ENABLE & !FIFO_EMPTY & rdy_q & SLWR_N was 1 in the previous cycle.
  - In that cycle FIFO_READ=1.
  - Next cycle: SLWR_N=0 and DATA=FIFO_DATA captured.
  - Max rate is one word per 2 cycles, which absorbs FX2 flag latency.
- Word count: increments per write. At PKT_WORDS-1 it wraps to 0 (FX2 auto-commit) and the idle counter clears.
- Idle counter: counts cycles with no write while WORD_CNT≠0; cleared on any write.
- Timeout: when idle counter == TIMEOUT (TIMEOUT≠0) and rdy_q=1, go to COMMIT.
- COMMIT: PKTEND_N=0 for exactly 1 cycle (SLWR_N=1 in the same cycle); WORD_CNT←0; idle counter←0; go to GAP.
- GAP: one cycle with no SLWR/PKTEND (FX2 setup time); then WRITE if ENABLE, else IDLE.
- ENABLE falls in WRITE: any registered write in flight completes; then IDLE. WORD_CNT is held, so a partial packet is still committed after timeout only once ENABLE returns.
- Simultaneous timeout and non-empty FIFO with rdy_q: the write wins and the timer restarts.
- WORD_CNT==0: no PKTEND is ever issued (no zero-length packets).
- rdy_q falls during WRITE: no new pops; the already-registered strobe still completes.
- Reset mid-operation: all outputs go to reset values immediately (async). Any popped but unwritten word is lost; this is acceptable and documented.

Optional Feature:
- Macro: USB_STREAM_PKT_CTRL_STATS_EN.
- With it: adds outputs PKT_CNT (16) and SHORT_PKT_CNT (16), wrapping counters of committed packets (full + timeout) and timeout commits only. Both clear on reset.
- Without it: the ports and logic are absent.

Decomposition:
- Package usb_stream_pkg: state encoding (IDLE/WRITE/COMMIT/GAP), EP6 address constant, default packet size.
- One sub-module, stream_idle_timer: loadable TIMEOUT_WIDTH counter with clear, enable and match output.

Test Plan:
- Reset, ENABLE=1, rdy=1, 3 words 0x0001..0x0003 → 3 SLWR_N pulses 2 cycles apart with matching DATA; after 10 idle cycles (TIMEOUT=10), one PKTEND_N pulse; WORD_CNT 3→0.
- 256 words continuous → WORD_CNT wraps to 0 and no PKTEND_N; with STATS_EN, PKT_CNT=1 and SHORT_PKT_CNT=0.
- FULL_N=0 after word 5 for 20 cycles, TIMEOUT=8 → no writes and no PKTEND while not ready; after FULL_N=1, PKTEND follows within 2 cycles; no word lost or duplicated.
- TIMEOUT=0 with 1 word written and 1000 idle cycles → no PKTEND_N; WORD_CNT stays 1.
- Word arrives on the same cycle the timeout matches → write occurs, no PKTEND, timer restarts.
- STREAM_RST_N asserted mid-burst → SLWR_N=1 and PKTEND_N=1 asynchronously; after release, the next burst restarts with WORD_CNT=0.

Source files
------------

// File: rtl/usb_stream_pkg.sv
// Shared types and constants for the FX2 slave-FIFO stream write path.
package usb_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    COMMIT = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic [1:0] EP6_ADDR          = 2'b10;
  localparam int         DEFAULT_PKT_WORDS = 256;

endpackage

// File: rtl/usb_stream_pkt_ctrl_if.sv
// Source-FIFO and FX2 slave-FIFO signals of the stream write sequencer.
// master = sequencer side, slave = FIFO/FX2 side.
interface usb_stream_pkt_ctrl_if;

  logic        FIFO_EMPTY;
  logic [15:0] FIFO_DATA;
  logic        FIFO_READ;
  logic        FULL_N;
  logic        FX2RDY;
  logic        SLWR_N;
  logic [15:0] DATA;
  logic        PKTEND_N;
  logic [1:0]  FIFOADDR;

  modport master (
    input  FIFO_EMPTY, FIFO_DATA, FULL_N, FX2RDY,
    output FIFO_READ, SLWR_N, DATA, PKTEND_N, FIFOADDR
  );

  modport slave (
    output FIFO_EMPTY, FIFO_DATA, FULL_N, FX2RDY,
    input  FIFO_READ, SLWR_N, DATA, PKTEND_N, FIFOADDR
  );

endinterface

// File: rtl/stream_idle_timer.sv
// Idle-cycle counter compared against a limit; clear has priority over enable.
// o_match is combinational from the count register and the limit input.
module stream_idle_timer #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_match
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_match = (r_cnt == i_limit);

endmodule

// File: rtl/usb_stream_pkt_ctrl.sv
// FX2 stream write sequencer: pops FWFT words, one registered SLWR_N per 2 cycles, PKTEND_N on idle timeout.
// Optional PKT_CNT/SHORT_PKT_CNT statistics under USB_STREAM_PKT_CTRL_STATS_EN.
module usb_stream_pkt_ctrl
  import usb_stream_pkg::*;
#(
  parameter int         PKT_WORDS     = DEFAULT_PKT_WORDS,
  parameter int         TIMEOUT_WIDTH = 16,
  parameter logic [1:0] EP_ADDR       = EP6_ADDR
) (
  input  logic                         STREAM_CLK,
  input  logic                         STREAM_RST_N,
  input  logic                         ENABLE,
  input  logic [TIMEOUT_WIDTH-1:0]     TIMEOUT,
  usb_stream_pkt_ctrl_if.master        bus,
  output logic [$clog2(PKT_WORDS)-1:0] WORD_CNT
`ifdef USB_STREAM_PKT_CTRL_STATS_EN
  ,
  output logic [15:0]                  PKT_CNT,
  output logic [15:0]                  SHORT_PKT_CNT
`endif
);

  localparam int            CW        = $clog2(PKT_WORDS);
  localparam logic [CW-1:0] LAST_WORD = CW'(PKT_WORDS - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_rdy_q;
  logic          r_slwr_n;
  logic          r_pktend_n;
  logic [15:0]   r_data;
  logic [CW-1:0] r_word_cnt;
  logic          w_write;
  logic          w_match;
  logic          w_timeout;
  logic          w_commit;
  logic          w_wrap;

  // r_slwr_n gating enforces a free cycle after every strobe to ride out FX2 flag latency.
  assign w_write   = (r_state == WRITE) & ENABLE & ~bus.FIFO_EMPTY & r_rdy_q & r_slwr_n;
  assign w_wrap    = w_write & (r_word_cnt == LAST_WORD);
  assign w_commit  = (r_state == COMMIT);
  assign w_timeout = (r_state == WRITE) & ENABLE & ~w_write & (r_word_cnt != '0) &
                     (TIMEOUT != '0) & w_match & r_rdy_q;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (ENABLE) w_next = WRITE;
      WRITE: begin
        if (!ENABLE)        w_next = IDLE;
        else if (w_timeout) w_next = COMMIT;
      end
      COMMIT:  w_next = GAP;
      GAP:     w_next = ENABLE ? WRITE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
    if (!STREAM_RST_N) r_state <= IDLE;
    else               r_state <= w_next;
  end

  always_ff @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
    if (!STREAM_RST_N) begin
      r_rdy_q    <= 1'b0;
      r_slwr_n   <= 1'b1;
      r_pktend_n <= 1'b1;
      r_data     <= '0;
      r_word_cnt <= '0;
    end else begin
      r_rdy_q    <= bus.FULL_N & bus.FX2RDY;
      r_slwr_n   <= ~w_write;
      r_pktend_n <= ~(w_next == COMMIT);
      if (w_write) r_data <= bus.FIFO_DATA;
      if (w_commit || w_wrap) r_word_cnt <= '0;
      else if (w_write)       r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  // Counting holds once the limit is reached so a held match survives rdy/ENABLE drops.
  stream_idle_timer #(
    .W (TIMEOUT_WIDTH)
  ) u_idle_timer (
    .i_clk   (STREAM_CLK),
    .i_rst_n (STREAM_RST_N),
    .i_clr   (w_write | w_commit),
    .i_en    ((r_word_cnt != '0) & ~w_match),
    .i_limit (TIMEOUT),
    .o_match (w_match)
  );

  assign bus.FIFO_READ = w_write;
  assign bus.SLWR_N    = r_slwr_n;
  assign bus.DATA      = r_data;
  assign bus.PKTEND_N  = r_pktend_n;
  assign bus.FIFOADDR  = EP_ADDR;
  assign WORD_CNT      = r_word_cnt;

`ifdef USB_STREAM_PKT_CTRL_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_short_cnt;

  always_ff @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
    if (!STREAM_RST_N) begin
      r_pkt_cnt   <= '0;
      r_short_cnt <= '0;
    end else begin
      if (w_wrap || w_commit) r_pkt_cnt   <= r_pkt_cnt + 1'b1;
      if (w_commit)           r_short_cnt <= r_short_cnt + 1'b1;
    end
  end

  assign PKT_CNT       = r_pkt_cnt;
  assign SHORT_PKT_CNT = r_short_cnt;
`endif

endmodule

// File: tb/tb_usb_stream_pkt_ctrl.sv
// Scoreboard bench for usb_stream_pkt_ctrl: queued source FIFO model, data checked on every SLWR_N strobe.
module tb_usb_stream_pkt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] timeout = 16'd10;
  logic [7:0]  word_cnt;
`ifdef USB_STREAM_PKT_CTRL_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] short_cnt;
`endif

  usb_stream_pkt_ctrl_if u_if ();

  usb_stream_pkt_ctrl u_dut (
    .STREAM_CLK    (clk),
    .STREAM_RST_N  (rst_n),
    .ENABLE        (enable),
    .TIMEOUT       (timeout),
    .bus           (u_if),
    .WORD_CNT      (word_cnt)
`ifdef USB_STREAM_PKT_CTRL_STATS_EN
    ,
    .PKT_CNT       (pkt_cnt),
    .SHORT_PKT_CNT (short_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_wr = 0;
  int          n_pkt = 0;
  int          cyc = 0;
  int          last_wr_cyc = 0;
  int          last_pkt_cyc = 0;
  int          wr_cyc_q[$];
  logic [15:0] src_q[$];
  logic [15:0] exp_q[$];
  bit          rd_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  always @(posedge clk) cyc++;

  // Source FIFO model: a pop seen mid-cycle takes effect just after the following edge.
  always @(posedge clk) begin
    #2;
    if (rd_seen) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      rd_seen = 1'b0;
    end
    u_if.FIFO_EMPTY = (src_q.size() == 0);
    u_if.FIFO_DATA  = (src_q.size() > 0) ? src_q[0] : 16'h0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      rd_seen = u_if.FIFO_READ;
      if (u_if.SLWR_N == 1'b0) begin
        n_wr++;
        last_wr_cyc = cyc;
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) chk("sb_unexpected_write", 32'(exp_q.size()), 32'd1);
        else                   chk("sb_data", 32'(u_if.DATA), 32'(exp_q.pop_front()));
      end
      if (u_if.PKTEND_N == 1'b0) begin
        n_pkt++;
        last_pkt_cyc = cyc;
        chk("pktend_with_slwr", 32'(u_if.SLWR_N), 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_wr(input int target, input int budget, input string tag);
    int k = 0;
    while (n_wr < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, 32'(n_wr), 32'(target));
  endtask

  task automatic wait_pkt(input int target, input int budget, input string tag);
    int k = 0;
    while (n_pkt < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, 32'(n_pkt), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    int p0;
    int w0;
    u_if.FIFO_EMPTY = 1'b1;
    u_if.FIFO_DATA  = 16'h0;
    u_if.FULL_N     = 1'b1;
    u_if.FX2RDY     = 1'b1;

    // Reset state
    tick(3);
    chk("rst_slwr_n", 32'(u_if.SLWR_N), 32'd1);
    chk("rst_pktend_n", 32'(u_if.PKTEND_N), 32'd1);
    chk("rst_data", 32'(u_if.DATA), 32'd0);
    chk("rst_fifo_read", 32'(u_if.FIFO_READ), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("fifoaddr", 32'(u_if.FIFOADDR), 32'd2);
    rst_n = 1'b1;
    tick(2);

    // Three words then a timeout commit
    timeout = 16'd10;
    enable  = 1'b1;
    push(16'h0001);
    push(16'h0002);
    push(16'h0003);
    wait_wr(3, 50, "t1_writes");
    chk("t1_word_cnt3", 32'(word_cnt), 32'd3);
    chk("t1_gap01", 32'(wr_cyc_q[1] - wr_cyc_q[0]), 32'd2);
    chk("t1_gap12", 32'(wr_cyc_q[2] - wr_cyc_q[1]), 32'd2);
    wait_pkt(1, 40, "t1_pktend");
    chk("t1_pkt_delay_ok", 32'((last_pkt_cyc - last_wr_cyc) >= 10 && (last_pkt_cyc - last_wr_cyc) <= 12), 32'd1);
    tick(2);
    chk("t1_word_cnt0", 32'(word_cnt), 32'd0);
    chk("t1_single_pulse", 32'(n_pkt), 32'd1);
`ifdef USB_STREAM_PKT_CTRL_STATS_EN
    chk("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("t1_short_cnt", 32'(short_cnt), 32'd1);
`endif

    // Full packet: auto-commit boundary, no PKTEND
    base = n_wr;
    p0   = n_pkt;
    for (int i = 0; i < 256; i++) push(16'(16'h0100 + i));
    wait_wr(base + 256, 1200, "t2_writes");
    chk("t2_word_cnt_wrap", 32'(word_cnt), 32'd0);
    tick(30);
    chk("t2_no_pktend", 32'(n_pkt), 32'(p0));
`ifdef USB_STREAM_PKT_CTRL_STATS_EN
    chk("t2_pkt_cnt", 32'(pkt_cnt), 32'd2);
    chk("t2_short_cnt", 32'(short_cnt), 32'd1);
`endif

    // FX2 full stall after 5 words
    timeout = 16'd8;
    base = n_wr;
    for (int i = 0; i < 5; i++) push(16'(16'h0500 + i));
    wait_wr(base + 5, 40, "t3_writes");
    u_if.FULL_N = 1'b0;
    w0 = n_wr;
    p0 = n_pkt;
    tick(20);
    chk("t3_no_wr_stall", 32'(n_wr), 32'(w0));
    chk("t3_no_pkt_stall", 32'(n_pkt), 32'(p0));
    chk("t3_word_cnt5", 32'(word_cnt), 32'd5);
    u_if.FULL_N = 1'b1;
    wait_pkt(p0 + 1, 3, "t3_pkt_after_ready");
    tick(2);
    chk("t3_word_cnt0", 32'(word_cnt), 32'd0);
    chk("t3_none_lost", 32'(exp_q.size()), 32'd0);

    // TIMEOUT=0 never commits
    timeout = 16'd0;
    base = n_wr;
    p0   = n_pkt;
    push(16'h0A0A);
    wait_wr(base + 1, 20, "t4_write");
    tick(1000);
    chk("t4_no_pktend", 32'(n_pkt), 32'(p0));
    chk("t4_word_cnt1", 32'(word_cnt), 32'd1);
    timeout = 16'd5;
    wait_pkt(p0 + 1, 20, "t4_pkt_after_enable_tmo");
    tick(2);
    chk("t4_word_cnt0", 32'(word_cnt), 32'd0);

    // Word arrives on the match cycle: the write wins
    timeout = 16'd6;
    base = n_wr;
    p0   = n_pkt;
    push(16'h0B01);
    wait_wr(base + 1, 20, "t5_first_write");
    repeat (5) @(posedge clk);
    @(negedge clk);
    push(16'h0B02);
    @(negedge clk);
    #1;
    chk("t5_read_on_match", 32'(u_if.FIFO_READ), 32'd1);
    tick(3);
    chk("t5_no_pktend", 32'(n_pkt), 32'(p0));
    chk("t5_second_write", 32'(n_wr), 32'(base + 2));
    wait_pkt(p0 + 1, 20, "t5_pkt_later");
    chk("t5_timer_restarted", 32'((last_pkt_cyc - last_wr_cyc) >= 6), 32'd1);
    tick(2);

    // Asynchronous reset mid-burst
    timeout = 16'd10;
    base = n_wr;
    for (int i = 0; i < 20; i++) push(16'(16'h0C00 + i));
    wait_wr(base + 4, 40, "t6_writes_before_rst");
    chk("t6_slwr_low_before_rst", 32'(u_if.SLWR_N), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_slwr_n", 32'(u_if.SLWR_N), 32'd1);
    chk("t6_rst_pktend_n", 32'(u_if.PKTEND_N), 32'd1);
    chk("t6_rst_word_cnt", 32'(word_cnt), 32'd0);
`ifdef USB_STREAM_PKT_CTRL_STATS_EN
    chk("t6_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
`endif
    src_q.delete();
    exp_q.delete();
    rd_seen = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    base = n_wr;
    p0   = n_pkt;
    push(16'h0D01);
    push(16'h0D02);
    push(16'h0D03);
    wait_wr(base + 3, 40, "t6_writes_after_rst");
    chk("t6_word_cnt3", 32'(word_cnt), 32'd3);
    wait_pkt(p0 + 1, 40, "t6_pktend");
    tick(2);
    chk("t6_word_cnt0", 32'(word_cnt), 32'd0);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
